// File: rtl/ifetch_prefetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_prefetch_queue_pkg
// Shared types and constants for the instruction prefetch queue.
//   NOP_INSTR    : add x0,x0,x0, shown on deq_instr whenever the head is invalid
//   INSTR_W/PC_W : instruction and program-counter widths
//   ENTRY_W      : width of one queued {pc, instr} pair
//   pq_entry_t   : packed {pc, instr} queue entry
//   fetch_state_t: run/halted state of the fetch engine
// ----------------------------------------------------------------------------
package ifetch_prefetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int ENTRY_W = PC_W + INSTR_W;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0033;
    localparam logic [PC_W-1:0]    PC_STEP   = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } pq_entry_t;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// ifetch_prefetch_queue_if
// Bundles the memory-port, control and dequeue signals of the prefetch queue.
//   master : the queue itself (drives imem_req/imem_addr and the deq_* side)
//   slave  : the surrounding pipeline and memory
// Signals:
//   mem_busy    MEM stage owns the memory port this cycle
//   imem_req    queue fetches this cycle (combinational)
//   imem_addr   fetch address
//   imem_rdata  instruction returned in the same cycle
//   redirect    flush and restart fetch at redirect_pc
//   redirect_pc new fetch address
//   halt        end of program: flush and stop fetching
//   deq_ready   IF/ID register loads this cycle
//   deq_valid   head entry is valid
//   deq_pc      PC of the head entry
//   deq_instr   head instruction, NOP when deq_valid=0
//   count       number of occupied entries
// ----------------------------------------------------------------------------
interface ifetch_prefetch_queue_if
    import ifetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               mem_busy;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;
    logic               deq_ready;
    logic               deq_valid;
    logic [PC_W-1:0]    deq_pc;
    logic [INSTR_W-1:0] deq_instr;
    logic [CNT_W-1:0]   count;

    modport master (
        input  mem_busy,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        input  halt,
        input  deq_ready,
        output imem_req,
        output imem_addr,
        output deq_valid,
        output deq_pc,
        output deq_instr,
        output count
    );

    modport slave (
        output mem_busy,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        output halt,
        output deq_ready,
        input  imem_req,
        input  imem_addr,
        input  deq_valid,
        input  deq_pc,
        input  deq_instr,
        input  count
    );

endinterface

// File: rtl/ifetch_prefetch_queue_sync_fifo_pc_instr.sv
// ----------------------------------------------------------------------------
// sync_fifo_pc_instr
// DEPTH-entry synchronous FIFO of {pc, instr} pairs.
//   clk, rst : clock and synchronous active-high reset
//   flush    : discard all entries (pointers and count return to zero)
//   wr_en    : push wr_data at the write pointer
//   rd_en    : pop the head entry
//   rd_data  : head entry; a write only becomes visible the cycle after it
//   count    : registered occupancy
//   full     : count == DEPTH
//   empty    : count == 0
// Reset and flush take priority over any push or pop in the same cycle.
// ----------------------------------------------------------------------------
module sync_fifo_pc_instr
    import ifetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  pq_entry_t                  wr_data,
    input  logic                       rd_en,
    output pq_entry_t                  rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pq_entry_t        mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Storage carries no reset; the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_en && empty));

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && full));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_reg <= CNT_W'(DEPTH));

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_prefetch_queue
// Instruction prefetch buffer between the unified single-ported memory and
// the IF/ID register. Sequential instructions are fetched only in cycles the
// MEM stage leaves the memory port free, and up to DEPTH {pc, instr} pairs
// are buffered so that data accesses do not starve the front end.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : ifetch_prefetch_queue_if.master (memory port, redirect/halt,
//          dequeue handshake, occupancy count)
// Priority per cycle: rst > halt > redirect > {fetch, pop}.
// ----------------------------------------------------------------------------
module ifetch_prefetch_queue
    import ifetch_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    ifetch_prefetch_queue_if.master bus
);

    fetch_state_t     state_reg;
    logic [PC_W-1:0]  fpc_reg;

    logic             halted;
    logic             flush;
    logic             fetch_en;
    logic             deq_valid_int;
    logic             pop;
    pq_entry_t        wr_entry;
    pq_entry_t        head_entry;
    logic [$clog2(DEPTH):0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign halted = (state_reg == FETCH_HALTED);
    assign flush  = bus.redirect | bus.halt;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not free a slot for fetching until the next cycle. The memory
    // port is left alone while reset is applied.
    assign fetch_en = !rst && !halted && !bus.halt && !bus.redirect
                      && !bus.mem_busy && !fifo_full;

    // The head is hidden in a flush cycle so nothing stale reaches IF/ID.
    assign deq_valid_int = !fifo_empty && !bus.redirect && !bus.halt && !halted;
    assign pop           = deq_valid_int && bus.deq_ready;

    assign wr_entry.pc    = fpc_reg;
    assign wr_entry.instr = bus.imem_rdata;

    sync_fifo_pc_instr #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (fetch_en),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Halt freezes fpc and is sticky until reset. A redirect still updates
    // fpc while halted; fetching stays off regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH_RUN;
            fpc_reg   <= RESET_PC;
        end else if (bus.halt) begin
            state_reg <= FETCH_HALTED;
        end else if (bus.redirect) begin
            fpc_reg <= align_word(bus.redirect_pc);
        end else if (fetch_en) begin
            fpc_reg <= fpc_reg + PC_STEP;
        end
    end

    assign bus.imem_req  = fetch_en;
    assign bus.imem_addr = fpc_reg;
    assign bus.deq_valid = deq_valid_int;
    assign bus.deq_pc    = deq_valid_int ? head_entry.pc    : '0;
    assign bus.deq_instr = deq_valid_int ? head_entry.instr : NOP_INSTR;
    assign bus.count     = fifo_count;

endmodule

// File: doc/ifetch_prefetch_queue.md
Name: ifetch_prefetch_queue

Overview:
- Instruction prefetch buffer between the unified single-ported memory and the IF/ID register.
- Fetches sequential instructions only in cycles when the MEM stage is not using memory (mem_busy = EX/MEM MemRead | MemWrite).
- Buffers up to DEPTH {pc, instr} pairs, so data accesses no longer starve the front end.
- Flushes on redirects (taken branch/jump) and stops permanently on program halt.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_busy  in  1  MEM stage owns the memory port this cycle.
- imem_req  out  1  queue uses the memory port this cycle (combinational).
- imem_addr  out  32  fetch address; equals fpc.
- imem_rdata  in  32  instruction read combinationally, same cycle as imem_req.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address.
- halt  in  1  endProgram reached; flush and stop fetching.
- deq_ready  in  1  IF/ID register loads this cycle (i.e. !stall).
- deq_valid  out  1  head entry is valid.
- deq_pc  out  32  PC of the head entry.
- deq_instr  out  32  head instruction; NOP 32'h0000_0033 (add x0,x0,x0) when deq_valid=0.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
Reset (rst=1 at posedge):
- fpc=RESET_PC; read/write pointers=0; count=0; halted=0.
- Outputs the next cycle: deq_valid=0, deq_instr=NOP, deq_pc=0, imem_req=(mem_busy==0).

Fetch:
- imem_req = !halted && !halt && !redirect && !mem_busy && (count < DEPTH).
- When imem_req=1, entry {fpc, imem_rdata} is written at the write pointer and fpc advances by 4.
- fpc wraps modulo 2^32.

Dequeue:
- deq_valid = (count != 0) && !redirect && !halt && !halted.
- A pop occurs when deq_valid && deq_ready; the read pointer advances by 1.

Latency and occupancy:
- No empty bypass: an instruction fetched in cycle N is first visible on deq_* in cycle N+1.
- Full: imem_req=0 even if a pop occurs in the same cycle. Full is evaluated on the registered count.
- Enqueue and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.

Redirect (redirect=1, halt=0):
- Takes priority over fetch and pop. Next state: count=0, pointers=0, fpc={redirect_pc[31:2],2'b00}.
- No fetch and no pop in the redirect cycle.

Halt:
- halt=1 sets halted=1 (sticky until rst) and flushes as a redirect does.
- fpc is held; redirect_pc is ignored in that cycle. Halt wins over a simultaneous redirect.
- While halted: imem_req=0, deq_valid=0, deq_instr=NOP.

Other boundary cases:
- mem_busy high for any number of cycles: the queue drains normally and does not refill.
- Reset mid-operation: all entries are discarded, no fetch occurs in the reset cycle, and the first post-reset fetch uses RESET_PC.
- count never exceeds DEPTH. An underflow (pop with count=0) is structurally impossible; flag it with an assertion.

Decomposition:
- Shared package/defines: NOP_INSTR = 32'h0000_0033; INSTR_W = 32; the pc+instr entry width (64).
- One natural sub-module, sync_fifo_pc_instr: a DEPTH x 64 synchronous FIFO with registered count, a no-bypass read port, and a flush input.
- The top level holds fpc, the halted flag, and the request/priority logic.

Test Plan:
1. Reset, then mem_busy=0 and deq_ready=1 continuously -> deq_pc = 0,4,8,12 on consecutive cycles; first deq_valid=1 one cycle after reset is released; count holds at 1.
2. deq_ready=0 for 6 cycles after reset -> count reaches 4 by the 4th cycle; imem_req=0 afterwards; imem_addr=16; queue holds pcs 0,4,8,12.
3. Queue at count=2, mem_busy=1 for 3 cycles with deq_ready=1 -> two pops, then deq_valid=0 and deq_instr=0x00000033; fetch resumes when mem_busy falls.
4. count=3, redirect=1 with redirect_pc=0x43 -> next cycle count=0 and imem_addr=0x40; first dequeued pc after refetch is 0x40.
5. halt and redirect asserted together with count=2 -> count=0, imem_req=0 thereafter, deq_valid=0 forever, fpc unchanged; rst restores fetch at RESET_PC.
6. count=2 with a simultaneous fetch and pop -> count stays 2 and FIFO order is preserved; assert rst mid-run -> count=0, next fetch addr=RESET_PC.
